// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - opcode constants, error codes and FSM states for the instruction sequencer
package seq_pkg;

  localparam int OP_NOP   = 0;
  localparam int OP_CFG   = 1;
  localparam int OP_START = 2;
  localparam int OP_SYNC  = 3;
  localparam int OP_LOOP  = 4;
  localparam int OP_ENDL  = 5;
  localparam int OP_EOC   = 31;

  typedef enum logic [1:0] {
    ERR_ILLEGAL     = 2'd0,
    ERR_STACK_FULL  = 2'd1,
    ERR_STACK_EMPTY = 2'd2,
    ERR_BAD_ENG     = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEC,
    ST_WAIT,
    ST_HALT,
    ST_ERR
  } state_e;

endpackage

// File: rtl/seq_loop_stack.sv
// rtl/seq_loop_stack.sv - LIFO of {return address, remaining count} for hardware loops
module seq_loop_stack #(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 12,
  parameter int DEPTH  = 4,
  localparam int SP_W  = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              dec,
  input  logic              clr,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [CNT_W-1:0]  push_cnt,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] top_addr,
  output logic [CNT_W-1:0]  top_cnt
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q  [DEPTH];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;

  // top_idx wraps when empty; callers never read top in that case
  assign top_idx  = IDX_W'(sp - SP_W'(1));
  assign push_idx = IDX_W'(sp);
  assign full     = (sp == SP_W'(DEPTH));
  assign empty    = (sp == '0);
  assign top_addr = addr_q[top_idx];
  assign top_cnt  = cnt_q[top_idx];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sp <= '0;
    end else if (push) begin
      addr_q[push_idx] <= push_addr;
      cnt_q[push_idx]  <= push_cnt;
      sp               <= sp + SP_W'(1);
    end else if (pop) begin
      sp <= sp - SP_W'(1);
    end else if (dec) begin
      cnt_q[top_idx] <= cnt_q[top_idx] - CNT_W'(1);
    end
  end

endmodule

// File: rtl/insn_sequencer.sv
// rtl/insn_sequencer.sv - ROM-driven sequencer: config writes, engine dispatch/sync, loops
// Optional hardware loops (LOOP/ENDL and the loop stack) are built when SEQ_LOOP_EN is defined.
module insn_sequencer
  import seq_pkg::*;
#(
  parameter int IADDR_W    = 13,
  parameter int INSN_W     = 32,
  parameter int OP_W       = 5,
  parameter int NUM_CFG    = 8,
  parameter int NUM_ENG    = 4,
  parameter int LOOP_DEPTH = 4,
  parameter int CNT_W      = 12,
  localparam int CFG_IDX_W = $clog2(NUM_CFG),
  localparam int ENG_W     = $clog2(NUM_ENG),
  localparam int PAY_W     = INSN_W - OP_W,
  localparam int CFG_W     = PAY_W - CFG_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  output logic [IADDR_W-1:0]       iaddr,
  input  logic [INSN_W-1:0]        idata,
  output logic [NUM_CFG*CFG_W-1:0] cfg_flat,
  output logic [NUM_CFG-1:0]       cfg_we,
  output logic [NUM_ENG-1:0]       eng_start,
  input  logic [NUM_ENG-1:0]       eng_done,
  input  logic [NUM_ENG-1:0]       eng_idle,
  output logic                     busy,
  output logic                     halted,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [IADDR_W-1:0]       err_addr
);

  if (CNT_W > PAY_W || LOOP_DEPTH < 1) begin : g_bad_param
    $error("insn_sequencer: loop parameters do not fit the instruction payload");
  end

  state_e             state;
  err_code_e          err_code_q;
  logic [ENG_W-1:0]   wait_eng;
  logic [PAY_W-1:0]   p;
  int                 op_int;
  logic [IADDR_W-1:0] iaddr_nxt;
  logic [CFG_IDX_W-1:0] cfg_idx;
  logic [ENG_W-1:0]   start_eng;
  logic [NUM_ENG-1:0] eff_idle;
  logic               fault;
  err_code_e          fault_code;

  assign p         = idata[PAY_W-1:0];
  assign op_int    = int'(idata[INSN_W-1 -: OP_W]);
  assign iaddr_nxt = iaddr + IADDR_W'(1);
  assign cfg_idx   = p[PAY_W-1 -: CFG_IDX_W];
  assign start_eng = p[ENG_W-1:0];
  // an engine pulsed last cycle may not have dropped eng_idle yet
  assign eff_idle  = eng_idle & ~eng_start;
  assign err_code  = err_code_q;

`ifdef SEQ_LOOP_EN
  logic               stk_full, stk_empty, stk_push, stk_pop, stk_dec, stk_clr;
  logic [IADDR_W-1:0] stk_top_addr;
  logic [CNT_W-1:0]   stk_top_cnt;
  logic               dec_ok;

  assign dec_ok   = (state == ST_DEC) && !fault;
  assign stk_push = dec_ok && (op_int == OP_LOOP);
  assign stk_pop  = dec_ok && (op_int == OP_ENDL) && (stk_top_cnt == '0);
  assign stk_dec  = dec_ok && (op_int == OP_ENDL) && (stk_top_cnt != '0);
  assign stk_clr  = run && (state inside {ST_IDLE, ST_HALT, ST_ERR});

  seq_loop_stack #(.ADDR_W(IADDR_W), .CNT_W(CNT_W), .DEPTH(LOOP_DEPTH)) u_stack (
    .clk(clk), .rst(rst), .push(stk_push), .pop(stk_pop), .dec(stk_dec), .clr(stk_clr),
    .push_addr(iaddr_nxt), .push_cnt(p[CNT_W-1:0]), .full(stk_full), .empty(stk_empty),
    .top_addr(stk_top_addr), .top_cnt(stk_top_cnt)
  );
`endif

  always_comb begin
    fault      = 1'b0;
    fault_code = ERR_ILLEGAL;
    case (op_int)
      OP_NOP, OP_CFG, OP_SYNC, OP_EOC: ;
      OP_START: if (int'(start_eng) >= NUM_ENG) begin
        fault      = 1'b1;
        fault_code = ERR_BAD_ENG;
      end
`ifdef SEQ_LOOP_EN
      OP_LOOP: if (stk_full) begin
        fault      = 1'b1;
        fault_code = ERR_STACK_FULL;
      end
      OP_ENDL: if (stk_empty) begin
        fault      = 1'b1;
        fault_code = ERR_STACK_EMPTY;
      end
`endif
      default: fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      iaddr      <= '0;
      cfg_flat   <= '0;
      cfg_we     <= '0;
      eng_start  <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      err        <= 1'b0;
      err_code_q <= ERR_ILLEGAL;
      err_addr   <= '0;
      wait_eng   <= '0;
    end else begin
      cfg_we    <= '0;
      eng_start <= '0;
      case (state)
        ST_IDLE, ST_HALT, ST_ERR: if (run) begin
          state      <= ST_DEC;
          busy       <= 1'b1;
          iaddr      <= '0;
          halted     <= 1'b0;
          err        <= 1'b0;
          err_code_q <= ERR_ILLEGAL;
          err_addr   <= '0;
        end
        ST_DEC: begin
          if (fault) begin
            state      <= ST_ERR;
            busy       <= 1'b0;
            err        <= 1'b1;
            err_code_q <= fault_code;
            err_addr   <= iaddr;
          end else begin
            case (op_int)
              OP_NOP: iaddr <= iaddr_nxt;
              OP_CFG: begin
                cfg_flat[cfg_idx*CFG_W +: CFG_W] <= p[CFG_W-1:0];
                cfg_we[cfg_idx]                  <= 1'b1;
                iaddr                            <= iaddr_nxt;
              end
              OP_START: if (eff_idle[start_eng]) begin
                eng_start[start_eng] <= 1'b1;
                if (p[PAY_W-1]) begin
                  iaddr <= iaddr_nxt;
                end else begin
                  state    <= ST_WAIT;
                  wait_eng <= start_eng;
                end
              end
              OP_SYNC: if ((p[NUM_ENG-1:0] & ~eff_idle) == '0) iaddr <= iaddr_nxt;
`ifdef SEQ_LOOP_EN
              OP_LOOP: iaddr <= iaddr_nxt;
              OP_ENDL: iaddr <= (stk_top_cnt == '0) ? iaddr_nxt : stk_top_addr;
`endif
              OP_EOC: begin
                state  <= ST_HALT;
                busy   <= 1'b0;
                halted <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        // done is ignored while our own start pulse is still on the wire
        ST_WAIT: if (!eng_start[wait_eng] && eng_done[wait_eng]) begin
          state <= ST_DEC;
          iaddr <= iaddr_nxt;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_sequencer.sv
// tb/tb_insn_sequencer.sv - directed self-checking bench for insn_sequencer
module tb_insn_sequencer;

  logic         clk = 1'b0;
  logic         rst, run;
  logic [12:0]  iaddr;
  logic [31:0]  idata;
  logic [191:0] cfg_flat;
  logic [7:0]   cfg_we;
  logic [3:0]   eng_start, eng_done, eng_idle;
  logic         busy, halted, err;
  logic [1:0]   err_code;
  logic [12:0]  err_addr;
  logic [31:0]  rom [64];
  int           tests = 0;
  int           fails = 0;
  int           pulses;

  localparam logic [31:0] I_NOP  = {5'd0, 27'd0};
  localparam logic [31:0] I_ENDL = {5'd5, 27'd0};
  localparam logic [31:0] I_EOC  = {5'd31, 27'd0};

  always #5 clk = ~clk;
  assign idata = rom[iaddr[5:0]];

  insn_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .iaddr(iaddr), .idata(idata),
    .cfg_flat(cfg_flat), .cfg_we(cfg_we), .eng_start(eng_start), .eng_done(eng_done),
    .eng_idle(eng_idle), .busy(busy), .halted(halted), .err(err),
    .err_code(err_code), .err_addr(err_addr)
  );

  function automatic logic [31:0] i_cfg(input logic [2:0] r, input logic [23:0] d);
    return {5'd1, r, d};
  endfunction
  function automatic logic [31:0] i_start(input logic [1:0] e, input logic nw);
    return {5'd2, nw, 24'd0, e};
  endfunction
  function automatic logic [31:0] i_sync(input logic [3:0] m);
    return {5'd3, 23'd0, m};
  endfunction
  function automatic logic [31:0] i_loop(input logic [11:0] c);
    return {5'd4, 15'd0, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = I_NOP;
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_stop(input int max);
    for (int i = 0; i < max && !(halted || err); i++) tick();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; eng_done = 4'h0; eng_idle = 4'hF;
    clear_rom();
    tick(); tick();
    chk("rst_iaddr", 192'(iaddr), 192'd0);
    chk("rst_cfg", cfg_flat, 192'd0);
    chk("rst_outs", 192'({cfg_we, eng_start, busy, halted, err, err_code, err_addr}), 192'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 192'(busy), 192'd0);

    // CFG reg 3
    rom[0] = i_cfg(3'd3, 24'h00ABCD); rom[1] = I_EOC;
    start_run();
    chk("run_busy", 192'({busy, iaddr}), 192'({1'b1, 13'd0}));
    tick();
    chk("cfg_we", 192'(cfg_we), 192'h08);
    chk("cfg_flat", cfg_flat, 192'(24'hABCD) << 72);
    tick();
    chk("cfg_we_drop", 192'(cfg_we), 192'h00);
    chk("cfg_halt", 192'({halted, busy}), 192'b10);
    chk("cfg_keep", cfg_flat, 192'(24'hABCD) << 72);

    // START e=2 with wait, done 5 cycles after the pulse
    clear_rom(); rom[0] = i_start(2'd2, 1'b0); rom[1] = I_EOC;
    start_run();
    tick();
    chk("start_pulse", 192'(eng_start), 192'b0100);
    chk("start_wait_busy", 192'({busy, iaddr}), 192'({1'b1, 13'd0}));
    tick();
    chk("start_pulse_drop", 192'(eng_start), 192'd0);
    tick(); tick(); tick(); tick();
    eng_done = 4'b0100;
    chk("start_held", 192'(iaddr), 192'd0);
    tick();
    eng_done = 4'b0000;
    chk("start_next", 192'({iaddr, busy, halted}), 192'({13'd1, 1'b1, 1'b0}));
    tick();
    chk("start_eoc", 192'(halted), 192'd1);

    // idle stall on engine 1
    clear_rom(); rom[0] = i_start(2'd1, 1'b1); rom[1] = I_EOC;
    eng_idle = 4'b1101;
    start_run();
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", 192'({iaddr, eng_start}), 192'd0);
      tick();
    end
    eng_idle = 4'hF;
    chk("stall_nopulse", 192'(eng_start), 192'd0);
    tick();
    chk("stall_pulse", 192'({iaddr, eng_start}), 192'({13'd1, 4'b0010}));

    // SYNC: empty mask is one cycle, then stall on engine 2
    clear_rom(); rom[0] = i_sync(4'b0000); rom[1] = i_sync(4'b0100); rom[2] = I_EOC;
    eng_idle = 4'b1011;
    start_run();
    tick();
    chk("sync_zero", 192'(iaddr), 192'd1);
    tick();
    chk("sync_stall", 192'(iaddr), 192'd1);
    eng_idle = 4'hF;
    tick();
    chk("sync_go", 192'(iaddr), 192'd2);
    wait_stop(10);

`ifdef SEQ_LOOP_EN
    // nested loops: 3 x 2 starts on engine 0
    clear_rom();
    rom[0] = i_loop(12'd2); rom[1] = i_loop(12'd1); rom[2] = i_start(2'd0, 1'b1);
    rom[3] = I_ENDL; rom[4] = I_ENDL; rom[5] = I_EOC;
    start_run();
    pulses = 0;
    for (int i = 0; i < 100 && !halted && !err; i++) begin
      tick();
      if (eng_start[0]) pulses++;
    end
    chk("loop_pulses", 192'(pulses), 192'd6);
    chk("loop_halt", 192'({halted, err}), 192'b10);

    // stack overflow on the 5th LOOP
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = i_loop(12'd0);
    rom[5] = I_EOC;
    start_run();
    wait_stop(20);
    chk("full_err", 192'({err, err_code, busy}), 192'({1'b1, 2'd1, 1'b0}));
    chk("full_addr", 192'(err_addr), 192'd4);
`else
    clear_rom(); rom[0] = i_loop(12'd0); rom[1] = I_EOC;
    start_run();
    wait_stop(20);
    chk("noloop_err", 192'({err, err_code, busy}), 192'({1'b1, 2'd0, 1'b0}));
    chk("noloop_addr", 192'(err_addr), 192'd0);
`endif
    clear_rom(); rom[0] = I_NOP; rom[1] = I_EOC;
    start_run();
    chk("restart1", 192'({err, busy, iaddr}), 192'({1'b0, 1'b1, 13'd0}));
    wait_stop(20);
    chk("restart1_halt", 192'(halted), 192'd1);

    // illegal opcode 7 at address 1
    clear_rom(); rom[0] = I_NOP; rom[1] = {5'd7, 27'd0};
    start_run();
    wait_stop(20);
    chk("illegal_err", 192'({err, err_code, halted}), 192'({1'b1, 2'd0, 1'b0}));
    chk("illegal_addr", 192'(err_addr), 192'd1);
    clear_rom(); rom[0] = I_NOP; rom[1] = I_EOC;
    start_run();
    chk("restart2", 192'({err, busy, iaddr}), 192'({1'b0, 1'b1, 13'd0}));
    wait_stop(20);

    // reset while waiting on engine 3
    clear_rom(); rom[0] = i_start(2'd3, 1'b0); rom[1] = I_EOC;
    start_run();
    tick();
    tick();
    chk("pre_rst_wait", 192'({busy, iaddr}), 192'({1'b1, 13'd0}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wait", 192'({busy, iaddr, eng_start, halted}), 192'd0);
    eng_done = 4'b1000;
    tick(); tick(); tick();
    eng_done = 4'b0000;
    chk("rst_ignore_done", 192'({busy, iaddr, halted, err}), 192'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
